// File: rtl/debug_seq.sv
// rtl/debug_seq.sv - debug request sequencer fanning register, mode and multi-step commands out to cpu cores
// One request is in flight at a time; every output is a register loaded from next-state values.
module debug_seq #(
  parameter int CORES      = 8,
  parameter int LOG_CORES  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [LOG_CORES-1:0]             req_sel,
  input  logic                             req_bcast,
  input  logic [4:0]                       req_addr,
  input  logic                             req_we,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             resp_valid,
  output logic [DATA_WIDTH-1:0]            resp_rdata,
  input  logic [CORES-1:0]                 reg_stopped,
  input  logic [CORES*DATA_WIDTH-1:0]      reg_rdata,
  output logic [CORES*2-1:0]               cpu_mode,
  output logic [CORES*4-1:0]               reg_sel,
  output logic [CORES-1:0]                 reg_we,
  output logic [CORES*DATA_WIDTH-1:0]      reg_wdata
);

  typedef enum logic [2:0] {IDLE, ACCESS, CMD, STEP, WAIT, RESP} state_t;

  localparam logic [4:0] ADDR_MODE = 5'b10000;
  localparam logic [4:0] ADDR_STEP = 5'b10001;

  state_t r_state;
  state_t w_state_n;

  logic [LOG_CORES-1:0]        r_sel;
  logic                        r_bcast;
  logic [4:0]                  r_addr;
  logic                        r_we;
  logic [DATA_WIDTH-1:0]       r_wdata;
  logic [STEP_WIDTH-1:0]       r_count;
  logic [STEP_WIDTH-1:0]       w_count_n;

  logic                        r_req_ready;
  logic                        r_resp_valid;
  logic [DATA_WIDTH-1:0]       r_resp_rdata;
  logic [CORES*2-1:0]          r_cpu_mode;
  logic [CORES*4-1:0]          r_reg_sel;
  logic [CORES-1:0]            r_reg_we;
  logic [CORES*DATA_WIDTH-1:0] r_reg_wdata;

  logic                        w_acc;
  logic [LOG_CORES-1:0]        w_sel_n;
  logic                        w_bcast_n;
  logic [4:0]                  w_addr_n;
  logic                        w_we_n;
  logic [DATA_WIDTH-1:0]       w_wdata_n;
  logic [CORES-1:0]            w_tgt;
  logic [CORES-1:0]            w_tgt_n;
  logic                        w_multi;
  logic                        w_all_stopped;
  logic [DATA_WIDTH-1:0]       w_rdata_sel;
  logic                        w_stop_sel;
  logic [DATA_WIDTH-1:0]       w_rdata_n;
  logic [CORES*2-1:0]          w_cpu_mode_n;
  logic [CORES*4-1:0]          w_reg_sel_n;
  logic [CORES-1:0]            w_reg_we_n;
  logic [CORES*DATA_WIDTH-1:0] w_reg_wdata_n;

  // Broadcast only applies to writes; a select beyond CORES matches no core.
  function automatic logic [CORES-1:0] targets(input logic [LOG_CORES-1:0] sel,
                                               input logic bcast, input logic we);
    logic [CORES-1:0] t;
    t = '0;
    for (int c = 0; c < CORES; c++) begin
      t[c] = (bcast && we) || (sel == LOG_CORES'(c));
    end
    return t;
  endfunction

  assign w_acc     = req_valid && r_req_ready;
  assign w_sel_n   = w_acc ? req_sel   : r_sel;
  assign w_bcast_n = w_acc ? req_bcast : r_bcast;
  assign w_addr_n  = w_acc ? req_addr  : r_addr;
  assign w_we_n    = w_acc ? req_we    : r_we;
  assign w_wdata_n = w_acc ? req_wdata : r_wdata;

  assign w_tgt         = targets(r_sel, r_bcast, r_we);
  assign w_tgt_n       = targets(w_sel_n, w_bcast_n, w_we_n);
  assign w_multi       = r_we && (r_addr == ADDR_STEP);
  assign w_all_stopped = ((reg_stopped & w_tgt) == w_tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_state_n = req_addr[4] ? CMD : ACCESS;
      ACCESS:  w_state_n = RESP;
      CMD:     w_state_n = (w_multi && (r_count != '0) && (w_tgt != '0)) ? STEP : RESP;
      STEP:    w_state_n = WAIT;
      WAIT:    if (w_all_stopped) w_state_n = (r_count == STEP_WIDTH'(1)) ? RESP : STEP;
      RESP:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_count_n = r_count;
    if (w_acc && req_we && (req_addr == ADDR_STEP)) begin
      w_count_n = req_wdata[STEP_WIDTH-1:0];
    end else if ((r_state == WAIT) && w_all_stopped) begin
      w_count_n = r_count - STEP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= '0;
      r_bcast <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_n;
      if (w_acc) begin
        r_sel   <= req_sel;
        r_bcast <= req_bcast;
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    w_rdata_sel = '0;
    w_stop_sel  = 1'b0;
    for (int c = 0; c < CORES; c++) begin
      if (r_sel == LOG_CORES'(c)) begin
        w_rdata_sel = reg_rdata[c*DATA_WIDTH +: DATA_WIDTH];
        w_stop_sel  = reg_stopped[c];
      end
    end
  end

  // Read data is captured on the edge that leaves ACCESS or CMD; writes keep the last value.
  always_comb begin
    w_rdata_n = r_resp_rdata;
    if (!r_we && (r_state == ACCESS)) begin
      w_rdata_n = w_rdata_sel;
    end else if (!r_we && (r_state == CMD)) begin
      w_rdata_n = '0;
      if (w_tgt != '0) begin
        if (r_addr == ADDR_MODE)      w_rdata_n = DATA_WIDTH'(w_stop_sel);
        else if (r_addr == ADDR_STEP) w_rdata_n = DATA_WIDTH'(reg_stopped);
      end
    end
  end

  always_comb begin
    w_cpu_mode_n  = '0;
    w_reg_sel_n   = '0;
    w_reg_we_n    = '0;
    w_reg_wdata_n = '0;
    for (int c = 0; c < CORES; c++) begin
      if (w_tgt_n[c]) begin
        if (w_state_n == ACCESS) begin
          w_reg_sel_n[c*4 +: 4] = w_addr_n[3:0];
          w_reg_we_n[c]         = w_we_n;
          if (w_we_n) w_reg_wdata_n[c*DATA_WIDTH +: DATA_WIDTH] = w_wdata_n;
        end
        if ((w_state_n == CMD) && w_we_n && (w_addr_n == ADDR_MODE)) begin
          w_cpu_mode_n[c*2 +: 2] = w_wdata_n[1:0];
        end
        if (w_state_n == STEP) begin
          w_cpu_mode_n[c*2 +: 2] = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_cpu_mode   <= '0;
      r_reg_sel    <= '0;
      r_reg_we     <= '0;
      r_reg_wdata  <= '0;
    end else begin
      r_req_ready  <= (w_state_n == IDLE);
      r_resp_valid <= (w_state_n == RESP);
      r_resp_rdata <= w_rdata_n;
      r_cpu_mode   <= w_cpu_mode_n;
      r_reg_sel    <= w_reg_sel_n;
      r_reg_we     <= w_reg_we_n;
      r_reg_wdata  <= w_reg_wdata_n;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign cpu_mode   = r_cpu_mode;
  assign reg_sel    = r_reg_sel;
  assign reg_we     = r_reg_we;
  assign reg_wdata  = r_reg_wdata;

endmodule

// File: tb/tb_debug_seq.sv
// tb/tb_debug_seq.sv - self-checking bench for debug_seq with a cycle-level expectation model
// Cores are modelled as dropping reg_stopped for dly cycles after each step pulse.
module tb_debug_seq;

  localparam int CORES = 8;
  localparam int LOGC  = 4;
  localparam int DW    = 16;
  localparam int SW    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [LOGC-1:0]  req_sel = '0;
  logic             req_bcast = 1'b0;
  logic [4:0]       req_addr = '0;
  logic             req_we = 1'b0;
  logic [DW-1:0]    req_wdata = '0;
  logic             resp_valid;
  logic [DW-1:0]    resp_rdata;
  logic [CORES-1:0] reg_stopped;
  logic [CORES*DW-1:0] reg_rdata = '0;
  logic [CORES*2-1:0]  cpu_mode;
  logic [CORES*4-1:0]  reg_sel;
  logic [CORES-1:0]    reg_we;
  logic [CORES*DW-1:0] reg_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int dly   = 0;
  int cnt [CORES];
  logic [CORES-1:0] stop_mask = '1;
  logic [DW-1:0]    exp_rdata = '0;

  debug_seq #(.CORES(CORES), .LOG_CORES(LOGC), .DATA_WIDTH(DW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_bcast(req_bcast), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .reg_stopped(reg_stopped), .reg_rdata(reg_rdata), .cpu_mode(cpu_mode),
    .reg_sel(reg_sel), .reg_we(reg_we), .reg_wdata(reg_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    for (int c = 0; c < CORES; c++) begin
      if (rst)                             cnt[c] <= 0;
      else if (cpu_mode[c*2 +: 2] == 2'b11) cnt[c] <= dly;
      else if (cnt[c] > 0)                 cnt[c] <= cnt[c] - 1;
    end
  end

  always_comb begin
    reg_stopped = '0;
    for (int c = 0; c < CORES; c++) reg_stopped[c] = stop_mask[c] && (cnt[c] == 0);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour: one decode cycle, response on the second sample after acceptance;
  // a multi-step of n iterations adds n*(pulse + dly low cycles + one observing cycle).
  task automatic run_req(input int sel, input logic bc, input logic [4:0] addr,
                         input logic we, input logic [DW-1:0] wd, input string tag);
    logic [CORES-1:0]    tgt;
    logic [CORES*2-1:0]  em;
    logic [CORES*4-1:0]  es;
    logic [CORES-1:0]    ew;
    logic [CORES*DW-1:0] ed;
    logic [DW-1:0]       rd_exp;
    int n, kr, k;
    tgt = '0;
    for (int c = 0; c < CORES; c++) tgt[c] = (bc && we) || (sel == c);
    n  = (we && addr == 5'b10001 && tgt != '0) ? int'(wd[SW-1:0]) : 0;
    kr = 2 + n * (dly + 2);
    rd_exp = '0;
    if (tgt != '0) begin
      if (!addr[4])               rd_exp = reg_rdata[sel*DW +: DW];
      else if (addr == 5'b10000)  rd_exp = DW'(stop_mask[sel]);
      else if (addr == 5'b10001)  rd_exp = DW'(stop_mask);
    end
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " ready_before"}, req_ready, 1'b1);
    req_valid = 1'b1; req_sel = LOGC'(sel); req_bcast = bc;
    req_addr = addr;  req_we = we;          req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (k = 1; k <= kr + 1; k++) begin
      if (k > 1) @(negedge clk);
      em = '0; es = '0; ew = '0; ed = '0;
      for (int c = 0; c < CORES; c++) begin
        if (tgt[c]) begin
          if (k == 1 && !addr[4]) begin
            es[c*4 +: 4] = addr[3:0];
            ew[c] = we;
            ed[c*DW +: DW] = we ? wd : '0;
          end
          if (k == 1 && we && addr == 5'b10000) em[c*2 +: 2] = wd[1:0];
          if (n > 0 && k >= 2 && k < kr && ((k - 2) % (dly + 2)) == 0) em[c*2 +: 2] = 2'b11;
        end
      end
      if (k == kr && !we) exp_rdata = rd_exp;
      chk($sformatf("%s cpu_mode k=%0d", tag, k), cpu_mode, em);
      chk($sformatf("%s reg_sel k=%0d", tag, k), reg_sel, es);
      chk($sformatf("%s reg_we k=%0d", tag, k), reg_we, ew);
      chk($sformatf("%s reg_wdata k=%0d", tag, k), reg_wdata, ed);
      chk($sformatf("%s resp_valid k=%0d", tag, k), resp_valid, (k == kr));
      chk($sformatf("%s req_ready k=%0d", tag, k), req_ready, (k == kr + 1));
      if (k >= kr) chk($sformatf("%s resp_rdata k=%0d", tag, k), resp_rdata, exp_rdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, sel;
    logic [DW-1:0] wd;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready", req_ready, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_rdata", resp_rdata, '0);
    chk("rst cpu_mode", cpu_mode, '0);
    chk("rst reg_sel", reg_sel, '0);
    chk("rst reg_we", reg_we, '0);
    chk("rst reg_wdata", reg_wdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", req_ready, 1'b1);

    // Directed cases
    for (int c = 0; c < CORES; c++) reg_rdata[c*DW +: DW] = DW'(16'h1000 + c);
    run_req(2, 1'b0, 5'b00101, 1'b1, 16'h1234, "reg_write_c2");
    reg_rdata[3*DW +: DW] = 16'hBEEF;
    run_req(3, 1'b0, 5'b00111, 1'b0, 16'h0000, "reg_read_c3");
    run_req(0, 1'b1, 5'b10000, 1'b1, 16'h0002, "bcast_run");
    dly = 4; stop_mask = '1;
    run_req(1, 1'b0, 5'b10001, 1'b1, 16'h0003, "mstep3");
    run_req(1, 1'b0, 5'b10001, 1'b1, 16'h0000, "mstep0");
    run_req(9, 1'b0, 5'b10001, 1'b1, 16'h0005, "mstep_sel9");
    run_req(9, 1'b0, 5'b00010, 1'b0, 16'h0000, "read_sel9");
    dly = 0; stop_mask = 8'hA5;
    run_req(5, 1'b0, 5'b10000, 1'b0, 16'h0000, "read_stop_c5");
    run_req(6, 1'b0, 5'b10000, 1'b0, 16'h0000, "read_stop_c6");
    run_req(4, 1'b1, 5'b10001, 1'b0, 16'h0000, "read_bitmap");
    run_req(4, 1'b0, 5'b10110, 1'b0, 16'h0000, "read_other");
    run_req(4, 1'b1, 5'b10011, 1'b1, 16'hFFFF, "write_noop");

    // Reset while waiting for a step to complete
    dly = 4; stop_mask = '1;
    @(negedge clk);
    req_valid = 1'b1; req_sel = 4'd1; req_bcast = 1'b0;
    req_addr = 5'b10001; req_we = 1'b1; req_wdata = 16'h0003;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("wait ready", req_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst cpu_mode", cpu_mode, '0);
    chk("midrst resp_valid", resp_valid, 1'b0);
    chk("midrst resp_rdata", resp_rdata, '0);
    chk("midrst ready", req_ready, 1'b0);
    exp_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst hold resp_valid", resp_valid, 1'b0);
      chk("midrst hold cpu_mode", cpu_mode, '0);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("postrst resp_valid", resp_valid, 1'b0);
      chk("postrst cpu_mode", cpu_mode, '0);
    end
    run_req(1, 1'b0, 5'b10001, 1'b1, 16'h0002, "mstep_after_rst");

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < CORES; c++) reg_rdata[c*DW +: DW] = DW'($urandom);
      kind = $urandom_range(0, 5);
      sel  = $urandom_range(0, 9);
      wd   = DW'($urandom);
      dly  = 0;
      stop_mask = CORES'($urandom);
      case (kind)
        0: run_req(sel, 1'($urandom), {1'b0, 4'($urandom)}, 1'b1, wd, "rnd_reg_wr");
        1: run_req(sel, 1'($urandom), {1'b0, 4'($urandom)}, 1'b0, wd, "rnd_reg_rd");
        2: run_req(sel, 1'($urandom), 5'b10000, 1'b1, wd, "rnd_mode");
        3: begin
          dly = $urandom_range(0, 3);
          stop_mask = '1;
          wd[SW-1:0] = SW'($urandom_range(0, 3));
          run_req(sel, 1'($urandom), 5'b10001, 1'b1, wd, "rnd_mstep");
        end
        4: run_req(sel, 1'($urandom), {4'b1000, 1'($urandom)} + 5'($urandom_range(0, 3)), 1'b0, wd, "rnd_ctl_rd");
        default: run_req(sel, 1'($urandom), 5'b10010 + 5'($urandom_range(0, 13)), 1'b1, wd, "rnd_noop");
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
